empty_ptr_fifo: RTL and testbench
=================================

# empty_ptr_fifo

Storage of free data-table addresses for the hash table. It is filled by the init engine after a synchronous clear, hands the oldest free pointer to the insert engine, and takes back pointers released by the delete engine. It is a first-word-fall-through FIFO of depth 2**A_WIDTH, built on a registered-read RAM, with occupancy count and sticky error flags.

## Interface
- A_WIDTH, default TABLE_ADDR_WIDTH: pointer width; FIFO depth = 2**A_WIDTH.
- clk_i  in  1  single clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- srst_i  in  1  synchronous clear (from init engine `empty_ptr_storage_srst_o`).
- add_empty_ptr_i  in  A_WIDTH  pointer to push.
- add_empty_ptr_en_i  in  1  push strobe; one pointer per cycle.
- next_empty_ptr_o  out  A_WIDTH  oldest free pointer (head), valid when val high.
- next_empty_ptr_val_o  out  1  head valid (FIFO non-empty at output).
- next_empty_ptr_rd_ack_i  in  1  pop strobe; consumes head this cycle.
- empty_ptr_cnt_o  out  A_WIDTH+1  total stored pointers (RAM + output register).
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: pop attempted while val low.

## Operation
- State: wr_ptr, rd_ptr (A_WIDTH bits, natural wrap at 2**A_WIDTH), RAM-word count, output register + its valid bit, prefetch-in-flight bit.
- Push: accepted when empty_ptr_cnt_o < 2**A_WIDTH; writes RAM[wr_ptr], wr_ptr+1, count+1.
- Push when full (cnt == 2**A_WIDTH): dropped, overflow_o set. This applies even with a simultaneous pop.
- Pop: accepted when val high. Output register is freed and count−1.
- Pop with val low: ignored, underflow_o set.
- Prefetch: when the output register is empty or being popped, and the RAM holds unread words not already in flight, issue a RAM read at rd_ptr and advance rd_ptr. Data lands in the output register on the next edge.
- Simultaneous push and pop (not full, val high): both accepted, count unchanged.
- srst_i: zeroes pointers, count, val, in-flight bit and both flags. It has priority over a same-cycle push or pop, which are discarded. RAM contents are not cleared.
- Ordering: strict FIFO. Pops return pointers in push order.
- Count arithmetic is A_WIDTH+1 bits unsigned and never wraps; the guards above make over/underflow of the counter impossible.

## Timing
- Reset (rst_n_i low) values: next_empty_ptr_o = 0, next_empty_ptr_val_o = 0, empty_ptr_cnt_o = 0, overflow_o = 0, underflow_o = 0.
- Push into an empty FIFO sampled at edge k:
  - empty_ptr_cnt_o increments at edge k.
  - RAM read issued in cycle k..k+1.
  - next_empty_ptr_val_o high from edge k+2.
- Back-to-back pops: after a pop at edge k, the new head is valid at edge k+1 if a prefetch was in flight. Otherwise it is valid at edge k+2. Sustained rate of one pop per 2 cycles is the guaranteed minimum; the insert engine tolerates gaps.
- next_empty_ptr_o is stable while val is high and no pop occurs.
- Flags are sticky until srst_i or reset.
- Full init: srst at edge s, then pushes of 0..2**A_WIDTH−1 on consecutive edges s+1… Result: cnt = 2**A_WIDTH, head = 0 valid from edge s+3.

## Structure
- Package hash_table holds TABLE_ADDR_WIDTH; no new typedefs are required.
- One sub-module, empty_ptr_ram: simple dual-port RAM with 2**A_WIDTH words of A_WIDTH bits, one write port, one read port with 1-cycle registered read, no reset on the array.
- The FIFO control (pointers, count, prefetch, flags) lives in empty_ptr_fifo.

## Test plan
- A_WIDTH=4: srst, then push 0..15 on consecutive cycles -> cnt=16, head=0 valid 2 cycles after first push, no flags.
- From full: pop 3 times -> heads 0,1,2 observed in order, then head=3, cnt=13.
- Full (16): push 7, with and without simultaneous pop -> push dropped, overflow_o=1, cnt unchanged by the push.
- Empty: pop -> underflow_o=1, cnt=0, val stays 0. Then push 5 -> head=5 two cycles later.
- Wrap-around: fill 16, pop 10, push 20..29 (mod 16 values) -> pops return 10..15 then pushed values in order across pointer wrap.
- srst asserted together with push and pop mid-stream -> next cycle cnt=0, val=0, flags=0, discarded push never appears; rst_n_i low mid-operation -> all outputs 0 immediately.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared parameters for the hash table blocks.
package hash_table;
  localparam int TABLE_ADDR_WIDTH = 4;
endpackage

// File: rtl/empty_ptr_fifo_ram.sv
// Simple dual-port RAM for the free-pointer FIFO: one write port, one read port
// with a single-cycle registered read. The array has no reset.
module empty_ptr_ram #(
  parameter int A_WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [A_WIDTH-1:0] wr_addr_i,
  input  logic [A_WIDTH-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [A_WIDTH-1:0] rd_addr_i,
  output logic [A_WIDTH-1:0] rd_data_o
);
  localparam int DEPTH = 1 << A_WIDTH;

  logic [A_WIDTH-1:0] mem_q [DEPTH];
  logic [A_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    // Read data holds until the next read, so an unconsumed word stays put.
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/empty_ptr_fifo.sv
// First-word-fall-through FIFO of free data-table pointers, built on a
// registered-read RAM with a one-word output register and sticky error flags.
module empty_ptr_fifo
  import hash_table::*;
#(
  parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               srst_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic [A_WIDTH:0]   empty_ptr_cnt_o,
  output logic               overflow_o,
  output logic               underflow_o
);
  localparam logic [A_WIDTH:0]   DEPTH   = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH:0]   CNT_ONE = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [A_WIDTH-1:0] PTR_ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};

  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   cnt_q, cnt_d, ram_cnt_q, ram_cnt_d;
  logic [A_WIDTH-1:0] out_q, out_d;
  logic               val_q, val_d, in_flight_q, in_flight_d;
  logic               ovf_q, ovf_d, udf_q, udf_d;
  logic [A_WIDTH-1:0] rd_data;
  logic               full, push_acc, pop_acc, load, rd_en;

  // Pop handshake: val_o is the valid, rd_ack_i consumes the head in the same
  // cycle it is sampled with val_o high; an ack without valid is flagged, not stalled.
  assign full     = (cnt_q == DEPTH);
  assign push_acc = add_empty_ptr_en_i && !full;
  assign pop_acc  = next_empty_ptr_rd_ack_i && val_q;
  assign load     = in_flight_q && (!val_q || pop_acc);
  assign rd_en    = (ram_cnt_q != '0) && (!val_q || pop_acc);

  always_comb begin
    wr_ptr_d    = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d       = cnt_q;
    ram_cnt_d   = ram_cnt_q;
    if (push_acc && !pop_acc) cnt_d = cnt_q + CNT_ONE;
    else if (!push_acc && pop_acc) cnt_d = cnt_q - CNT_ONE;
    if (push_acc && !rd_en) ram_cnt_d = ram_cnt_q + CNT_ONE;
    else if (!push_acc && rd_en) ram_cnt_d = ram_cnt_q - CNT_ONE;
    out_d       = load ? rd_data : out_q;
    val_d       = load || (val_q && !pop_acc);
    in_flight_d = rd_en || (in_flight_q && !load);
    ovf_d       = ovf_q || (add_empty_ptr_en_i && full);
    udf_d       = udf_q || (next_empty_ptr_rd_ack_i && !val_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ram_cnt_q   <= '0;
      out_q       <= '0;
      val_q       <= 1'b0;
      in_flight_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else if (srst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ram_cnt_q   <= '0;
      out_q       <= '0;
      val_q       <= 1'b0;
      in_flight_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ram_cnt_q   <= ram_cnt_d;
      out_q       <= out_d;
      val_q       <= val_d;
      in_flight_q <= in_flight_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // Writes gated by srst so a discarded push never reaches the array.
  empty_ptr_ram #(.A_WIDTH(A_WIDTH)) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (push_acc && !srst_i),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (add_empty_ptr_i),
    .rd_en_i   (rd_en && !srst_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign next_empty_ptr_o     = out_q;
  assign next_empty_ptr_val_o = val_q;
  assign empty_ptr_cnt_o      = cnt_q;
  assign overflow_o           = ovf_q;
  assign underflow_o          = udf_q;
endmodule

// File: tb/tb_empty_ptr_fifo.sv
// Self-checking bench for empty_ptr_fifo with A_WIDTH=4: vector table,
// directed corner sequences and randomized traffic against a queue model.
module tb_empty_ptr_fifo;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          srst;
  logic [AW-1:0] push_data;
  logic          push_en;
  logic [AW-1:0] head;
  logic          val;
  logic          ack;
  logic [AW:0]   cnt;
  logic          ovf, udf;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  empty_ptr_fifo #(.A_WIDTH(AW)) dut (
    .clk_i                   (clk),
    .rst_n_i                 (rst_n),
    .srst_i                  (srst),
    .add_empty_ptr_i         (push_data),
    .add_empty_ptr_en_i      (push_en),
    .next_empty_ptr_o        (head),
    .next_empty_ptr_val_o    (val),
    .next_empty_ptr_rd_ack_i (ack),
    .empty_ptr_cnt_o         (cnt),
    .overflow_o              (ovf),
    .underflow_o             (udf)
  );

  typedef struct {
    logic          srst;
    logic          en;
    logic [AW-1:0] data;
    logic          ack;
    logic          exp_val;
    logic [AW-1:0] exp_head;
    logic [AW:0]   exp_cnt;
    logic          exp_ovf;
    logic          exp_udf;
  } vec_t;

  vec_t vecs[12];
  logic [AW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, then return inputs to idle.
  task automatic step(input logic s, input logic e, input logic [AW-1:0] d, input logic a);
    srst = s; push_en = e; push_data = d; ack = a;
    @(posedge clk);
    #1;
    srst = 1'b0; push_en = 1'b0; push_data = '0; ack = 1'b0;
  endtask

  task automatic wait_val(input string name);
    int n = 0;
    while (!val && n < 20) begin
      step(1'b0, 1'b0, '0, 1'b0);
      n++;
    end
    check(name, val, 1'b1);
  endtask

  task automatic pop_one(input logic [AW-1:0] exp_head);
    wait_val("pop_wait_val");
    check("pop_head", head, exp_head);
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic init_full();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, AW'(i), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stable;
    int size_before;
    logic r_srst, r_en, r_ack, pop_ok, m_ovf, m_udf;
    logic [AW-1:0] r_data;

    vecs[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 5'd1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 5'd1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 5'd1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0};

    // Clock/reset
    rst_n = 1'b0; srst = 1'b0; push_en = 1'b0; push_data = '0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_head", head, 0);
    check("rst_val", val, 0);
    check("rst_cnt", cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].srst, vecs[i].en, vecs[i].data, vecs[i].ack);
      check($sformatf("vec%0d_val", i), val, vecs[i].exp_val);
      check($sformatf("vec%0d_cnt", i), cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
      check($sformatf("vec%0d_udf", i), udf, vecs[i].exp_udf);
      if (vecs[i].exp_val) check($sformatf("vec%0d_head", i), head, vecs[i].exp_head);
    end

    // Full init with head latency
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    check("init_val_k", val, 0);
    check("init_cnt_k", cnt, 1);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    check("init_val_k1", val, 0);
    step(1'b0, 1'b1, 4'd2, 1'b0);
    check("init_val_k2", val, 1);
    check("init_head_k2", head, 0);
    for (int i = 3; i < DEPTH; i++) step(1'b0, 1'b1, AW'(i), 1'b0);
    check("full_cnt", cnt, DEPTH);
    check("full_head", head, 0);
    check("full_ovf", ovf, 0);
    check("full_udf", udf, 0);

    // Three pops from full
    for (int i = 0; i < 3; i++) pop_one(AW'(i));
    wait_val("pop3_val");
    check("pop3_head", head, 3);
    check("pop3_cnt", cnt, 13);

    // Overflow with and without a simultaneous pop
    init_full();
    step(1'b0, 1'b1, 4'd7, 1'b0);
    check("ovf_cnt", cnt, DEPTH);
    check("ovf_flag", ovf, 1);
    step(1'b0, 1'b1, 4'd7, 1'b1);
    check("ovf_pop_cnt", cnt, DEPTH - 1);
    check("ovf_pop_flag", ovf, 1);
    for (int i = 1; i < DEPTH; i++) pop_one(AW'(i));
    step(1'b0, 1'b0, '0, 1'b0);
    check("drain_cnt", cnt, 0);
    check("drain_val", val, 0);
    check("drain_udf", udf, 0);

    // Pointer wrap-around
    init_full();
    for (int i = 0; i < 10; i++) pop_one(AW'(i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, AW'((20 + i) % DEPTH), 1'b0);
    check("wrap_cnt", cnt, DEPTH);
    for (int i = 10; i < DEPTH; i++) pop_one(AW'(i));
    for (int i = 0; i < 10; i++) pop_one(AW'((20 + i) % DEPTH));
    step(1'b0, 1'b0, '0, 1'b0);
    check("wrap_end_cnt", cnt, 0);

    // srst colliding with push and pop mid-stream
    step(1'b0, 1'b0, '0, 1'b1);
    check("udf_empty", udf, 1);
    check("udf_empty_val", val, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, AW'(i + 1), 1'b0);
    wait_val("mid_val");
    step(1'b1, 1'b1, 4'd11, 1'b1);
    check("srst_cnt", cnt, 0);
    check("srst_val", val, 0);
    check("srst_udf", udf, 0);
    check("srst_ovf", ovf, 0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    check("srst_after_cnt", cnt, 0);
    check("srst_after_val", val, 0);

    // Async reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, AW'(i + 6), 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_head", head, 0);
    check("arst_val", val, 0);
    check("arst_cnt", cnt, 0);
    check("arst_ovf", ovf, 0);
    check("arst_udf", udf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against a queue model
    step(1'b1, 1'b0, '0, 1'b0);
    exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; stable = 0;
    for (int c = 0; c < 3000; c++) begin
      r_srst = ($urandom_range(0, 199) == 0);
      r_en   = ($urandom_range(0, 99) < ((c < 1500) ? 60 : 25));
      r_data = AW'($urandom_range(0, DEPTH - 1));
      pop_ok = (stable >= 2);
      r_ack  = 1'b0;
      if (pop_ok) r_ack = ($urandom_range(0, 1) == 1);
      else if (exp_q.size() == 0) r_ack = ($urandom_range(0, 7) == 0);
      size_before = exp_q.size();
      step(r_srst, r_en, r_data, r_ack);
      if (r_srst) begin
        exp_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; stable = 0;
      end else begin
        if (r_ack) begin
          if (pop_ok) void'(exp_q.pop_front());
          else m_udf = 1'b1;
        end
        if (r_en) begin
          if (size_before == DEPTH) m_ovf = 1'b1;
          else exp_q.push_back(r_data);
        end
        if (r_ack) stable = 0;
        else if (size_before > 0) stable = stable + 1;
        else stable = 0;
      end
      check("rnd_cnt", cnt, exp_q.size());
      check("rnd_ovf", ovf, m_ovf);
      check("rnd_udf", udf, m_udf);
      if (exp_q.size() == 0) check("rnd_val_empty", val, 0);
      else if (stable >= 2) check("rnd_val_ready", val, 1);
      if (val && exp_q.size() > 0) check("rnd_head", head, exp_q[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
